// File: rtl/ws_psum_if.sv
// Bus between the systolic array bottom row, the psum collector and the writeback path.
// The slave view belongs to the collector; the master view to its environment.
interface ws_psum_if #(
  parameter int unsigned SIZE = 16,
  parameter int unsigned IW   = 4,
  parameter int unsigned CW   = 3
);
  logic                  in_valid;
  logic                  in_first;
  logic                  in_last;
  logic [IW-1:0]         in_idx;
  logic [SIZE-1:0][31:0] sum_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [SIZE-1:0][31:0] out_data;
  logic [IW-1:0]         out_idx;
  logic [CW-1:0]         fifo_count;
  logic                  overflow;
  logic                  saturated;

  modport master (
    output in_valid, in_first, in_last, in_idx, sum_in, out_ready,
    input  out_valid, out_data, out_idx, fifo_count, overflow, saturated
  );

  modport slave (
    input  in_valid, in_first, in_last, in_idx, sum_in, out_ready,
    output out_valid, out_data, out_idx, fifo_count, overflow, saturated
  );
endinterface

// File: rtl/ws_psum_collector.sv
// Deskews column-skewed partial sums from the systolic array, accumulates them across
// K-tiles in an indexed bank, and queues completed vectors in a show-ahead FIFO.
module ws_psum_collector #(
  parameter int unsigned SIZE       = 16,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic      clk,
  input logic      rst,
  ws_psum_if.slave bus
);
  localparam int unsigned IW   = $clog2(DEPTH);
  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam int unsigned DW   = 32;
  localparam int unsigned NSTG = SIZE - 1;

  localparam logic [DW-1:0] MAX_V = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MIN_V = {1'b1, {(DW-1){1'b0}}};

  typedef logic [SIZE-1:0][DW-1:0] vec_t;

  // Signed 33-bit add with clipping; MSB of the result flags a clip.
  function automatic logic [DW:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {a[DW-1], a} + {b[DW-1], b};
    if (s[DW] != s[DW-1]) begin
      return {1'b1, (s[DW] ? MIN_V : MAX_V)};
    end
    return {1'b0, s[DW-1:0]};
  endfunction

  // Tag and valid pipeline: SIZE-1 stages so tags meet the last column.
  logic [NSTG-1:0] v_pipe;
  logic [NSTG-1:0] f_pipe;
  logic [NSTG-1:0] l_pipe;
  logic [IW-1:0]   i_pipe [NSTG];

  always_ff @(posedge clk) begin
    if (rst) begin
      v_pipe <= '0;
    end else begin
      v_pipe[0] <= bus.in_valid;
      for (int unsigned s = 1; s < NSTG; s++) begin
        v_pipe[s] <= v_pipe[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    f_pipe[0] <= bus.in_first;
    l_pipe[0] <= bus.in_last;
    i_pipe[0] <= bus.in_idx;
    for (int unsigned s = 1; s < NSTG; s++) begin
      f_pipe[s] <= f_pipe[s-1];
      l_pipe[s] <= l_pipe[s-1];
      i_pipe[s] <= i_pipe[s-1];
    end
  end

  logic          al_valid;
  logic          al_first;
  logic          al_last;
  logic [IW-1:0] al_idx;

  assign al_valid = v_pipe[NSTG-1];
  assign al_first = f_pipe[NSTG-1];
  assign al_last  = l_pipe[NSTG-1];
  assign al_idx   = i_pipe[NSTG-1];

  // Column c is delayed SIZE-1-c cycles; the last column arrives already aligned.
  vec_t aligned;

  for (genvar c = 0; c < int'(SIZE); c++) begin : g_deskew
    localparam int unsigned NST = SIZE - 1 - c;
    if (NST == 0) begin : g_pass
      assign aligned[c] = bus.sum_in[c];
    end else begin : g_pipe
      logic [DW-1:0] pipe [NST];
      always_ff @(posedge clk) begin
        pipe[0] <= bus.sum_in[c];
        for (int unsigned s = 1; s < NST; s++) begin
          pipe[s] <= pipe[s-1];
        end
      end
      assign aligned[c] = pipe[NST-1];
    end
  end

  // Accumulator bank: combinational read so back-to-back tiles to one index chain.
  vec_t            acc_mem [DEPTH];
  vec_t            acc_rd;
  vec_t            acc_new;
  logic [SIZE-1:0] clip;

  assign acc_rd = acc_mem[al_idx];

  always_comb begin
    acc_new = aligned;
    clip    = '0;
    if (!al_first) begin
      for (int unsigned c = 0; c < SIZE; c++) begin
        {clip[c], acc_new[c]} = sat_add(acc_rd[c], aligned[c]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (al_valid && !rst) begin
      acc_mem[al_idx] <= acc_new;
    end
  end

  logic saturated_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      saturated_q <= 1'b0;
    end else if (al_valid && (|clip)) begin
      saturated_q <= 1'b1;
    end
  end

  // Push stage between the accumulator and the FIFO.
  logic          push_valid;
  vec_t          push_data;
  logic [IW-1:0] push_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      push_valid <= 1'b0;
    end else begin
      push_valid <= al_valid && al_last;
    end
  end

  always_ff @(posedge clk) begin
    if (al_valid && al_last) begin
      push_data <= acc_new;
      push_idx  <= al_idx;
    end
  end

  // Completed-vector FIFO; a push into a full FIFO survives only with a same-cycle pop.
  vec_t          fifo_data [FIFO_DEPTH];
  logic [IW-1:0] fifo_idx  [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow_q;

  logic          full_c;
  logic          pop_c;
  logic          wr_c;
  logic          drop_c;
  logic [PW-1:0] wr_ptr_nxt;
  logic [PW-1:0] rd_ptr_nxt;
  logic [CW-1:0] count_nxt;
  logic          overflow_nxt;

  always_comb begin
    full_c       = (count == CW'(FIFO_DEPTH));
    pop_c        = (count != '0) && bus.out_ready;
    wr_c         = push_valid && (!full_c || pop_c);
    drop_c       = push_valid && full_c && !pop_c;
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    count_nxt    = count;
    overflow_nxt = overflow_q || drop_c;
    if (wr_c) begin
      wr_ptr_nxt = wr_ptr + PW'(1);
    end
    if (pop_c) begin
      rd_ptr_nxt = rd_ptr + PW'(1);
    end
    case ({wr_c, pop_c})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      count      <= count_nxt;
      overflow_q <= overflow_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_c) begin
      fifo_data[wr_ptr] <= push_data;
      fifo_idx[wr_ptr]  <= push_idx;
    end
  end

  // Head entry is masked while empty so the outputs read zero out of reset.
  logic out_valid_c;

  assign out_valid_c    = (count != '0);
  assign bus.out_valid  = out_valid_c;
  assign bus.out_data   = out_valid_c ? fifo_data[rd_ptr] : '0;
  assign bus.out_idx    = out_valid_c ? fifo_idx[rd_ptr] : '0;
  assign bus.fifo_count = count;
  assign bus.overflow   = overflow_q;
  assign bus.saturated  = saturated_q;

endmodule

// File: tb/tb_ws_psum_collector.sv
// Directed bench for ws_psum_collector at SIZE=4: a per-cycle stimulus schedule is
// replayed by a driver while one linear sequence checks outputs cycle by cycle.
module tb_ws_psum_collector;
  localparam int unsigned SIZE = 4;
  localparam int          NCYC = 128;

  logic clk = 1'b0;
  logic rst;

  ws_psum_if #(.SIZE(SIZE), .IW(4), .CW(3)) bus ();

  ws_psum_collector #(
    .SIZE(SIZE),
    .DEPTH(16),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  logic        s_rst   [NCYC];
  logic        s_valid [NCYC];
  logic        s_first [NCYC];
  logic        s_last  [NCYC];
  logic        s_ready [NCYC];
  logic [3:0]  s_idx   [NCYC];
  logic [31:0] s_sum   [NCYC][SIZE];

  int cyc;
  int n_assert;
  int n_fail;

  task automatic apply(input int t);
    rst          = s_rst[t];
    bus.in_valid = s_valid[t];
    bus.in_first = s_first[t];
    bus.in_last  = s_last[t];
    bus.in_idx   = s_idx[t];
    bus.out_ready = s_ready[t];
    for (int c = 0; c < int'(SIZE); c++) begin
      bus.sum_in[c] = s_sum[t][c];
    end
  endtask

  // Inputs for cycle n are applied 1ns after the edge that opens cycle n.
  initial begin
    cyc = 0;
    #1;
    apply(0);
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc < NCYC) apply(cyc);
    end
  end

  task automatic vec(input int t, input logic f, input logic l, input logic [3:0] idx,
                     input logic [31:0] v0, input logic [31:0] v1,
                     input logic [31:0] v2, input logic [31:0] v3);
    s_valid[t]      = 1'b1;
    s_first[t]      = f;
    s_last[t]       = l;
    s_idx[t]        = idx;
    s_sum[t][0]     = v0;
    s_sum[t + 1][1] = v1;
    s_sum[t + 2][2] = v2;
    s_sum[t + 3][3] = v3;
  endtask

  task automatic at(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cyc %0d: observed 0x%08h expected 0x%08h", tag, cyc, obs, exp);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    for (int t = 0; t < NCYC; t++) begin
      s_rst[t]   = 1'b0;
      s_valid[t] = 1'b0;
      s_first[t] = 1'b0;
      s_last[t]  = 1'b0;
      s_ready[t] = 1'b1;
      s_idx[t]   = 4'd0;
      for (int c = 0; c < int'(SIZE); c++) s_sum[t][c] = 32'd0;
    end
    for (int t = 0; t < 3; t++) s_rst[t] = 1'b1;

    vec(5, 1'b1, 1'b1, 4'd3, 32'd10, 32'd11, 32'd12, 32'd13);
    vec(12, 1'b1, 1'b0, 4'd2, 32'd1, 32'd2, 32'd3, 32'd4);
    vec(13, 1'b0, 1'b0, 4'd2, 32'd10, 32'd20, 32'd30, 32'd40);
    vec(14, 1'b0, 1'b1, 4'd2, 32'd100, 32'd200, 32'd300, 32'd400);
    vec(22, 1'b1, 1'b0, 4'd5, 32'h7FFF_FFF0, 32'd0, 32'd0, 32'd0);
    vec(23, 1'b0, 1'b1, 4'd5, 32'h0000_0100, 32'd0, 32'd0, 32'd0);
    vec(30, 1'b1, 1'b0, 4'd6, 32'h8000_0010, 32'd0, 32'd5, 32'd0);
    vec(31, 1'b0, 1'b1, 4'd6, 32'hFFFF_FF00, 32'd0, 32'd7, 32'd0);
    for (int t = 38; t <= 51; t++) s_ready[t] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      vec(40 + k, 1'b1, 1'b1, 4'(k), 32'(1000 + k), 32'd0, 32'd0, 32'(k));
    end
    s_rst[57] = 1'b1;
    s_rst[58] = 1'b1;
    for (int t = 59; t <= 67; t++) s_ready[t] = 1'b0;
    s_ready[69] = 1'b0;
    s_ready[70] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      vec(60 + k, 1'b1, 1'b1, 4'(8 + k), 32'(2000 + k), 32'd0, 32'd0, 32'd0);
    end
    vec(80, 1'b1, 1'b1, 4'd7, 32'd1, 32'd2, 32'd3, 32'd4);
    s_rst[82] = 1'b1;
    vec(82, 1'b1, 1'b1, 4'd1, 32'd5, 32'd6, 32'd7, 32'd8);
    vec(95, 1'b1, 1'b1, 4'd4, 32'd7, 32'hFFFF_FFFF, 32'd0, 32'd9);

    // Reset state
    at(3);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_sat", 32'(bus.saturated), 32'd0);
    chk("rst_idx", 32'(bus.out_idx), 32'd0);
    chk("rst_data0", bus.out_data[0], 32'd0);
    chk("rst_data3", bus.out_data[3], 32'd0);

    // Single-tile pass-through, latency T+5
    at(9);
    chk("single_early", 32'(bus.out_valid), 32'd0);
    at(10);
    chk("single_valid", 32'(bus.out_valid), 32'd1);
    chk("single_idx", 32'(bus.out_idx), 32'd3);
    chk("single_d0", bus.out_data[0], 32'd10);
    chk("single_d1", bus.out_data[1], 32'd11);
    chk("single_d2", bus.out_data[2], 32'd12);
    chk("single_d3", bus.out_data[3], 32'd13);
    at(11);
    chk("single_popped", 32'(bus.out_valid), 32'd0);

    // Three-tile accumulate into idx 2
    at(17);
    chk("acc_no_t1", 32'(bus.out_valid), 32'd0);
    at(18);
    chk("acc_no_t2", 32'(bus.out_valid), 32'd0);
    at(19);
    chk("acc_valid", 32'(bus.out_valid), 32'd1);
    chk("acc_count", 32'(bus.fifo_count), 32'd1);
    chk("acc_idx", 32'(bus.out_idx), 32'd2);
    chk("acc_d0", bus.out_data[0], 32'd111);
    chk("acc_d1", bus.out_data[1], 32'd222);
    chk("acc_d2", bus.out_data[2], 32'd333);
    chk("acc_d3", bus.out_data[3], 32'd444);
    at(20);
    chk("acc_popped", 32'(bus.out_valid), 32'd0);
    chk("acc_nosat", 32'(bus.saturated), 32'd0);

    // Positive and negative saturation
    at(26);
    chk("sat_not_yet", 32'(bus.saturated), 32'd0);
    at(27);
    chk("sat_flag", 32'(bus.saturated), 32'd1);
    at(28);
    chk("satp_valid", 32'(bus.out_valid), 32'd1);
    chk("satp_idx", 32'(bus.out_idx), 32'd5);
    chk("satp_d0", bus.out_data[0], 32'h7FFF_FFFF);
    chk("satp_d1", bus.out_data[1], 32'd0);
    at(36);
    chk("satn_valid", 32'(bus.out_valid), 32'd1);
    chk("satn_idx", 32'(bus.out_idx), 32'd6);
    chk("satn_d0", bus.out_data[0], 32'h8000_0000);
    chk("satn_d2", bus.out_data[2], 32'd12);
    chk("satn_flag", 32'(bus.saturated), 32'd1);

    // Overflow: five pushes into a depth-4 FIFO with no consumer
    at(48);
    chk("ovf_full_count", 32'(bus.fifo_count), 32'd4);
    chk("ovf_not_yet", 32'(bus.overflow), 32'd0);
    at(49);
    chk("ovf_count", 32'(bus.fifo_count), 32'd4);
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    chk("ovf_head", 32'(bus.out_idx), 32'd0);
    for (int k = 0; k < 4; k++) begin
      at(52 + k);
      chk("ovf_drain_idx", 32'(bus.out_idx), 32'(k));
      chk("ovf_drain_d0", bus.out_data[0], 32'(1000 + k));
      chk("ovf_drain_d3", bus.out_data[3], 32'(k));
    end
    at(56);
    chk("ovf_empty", 32'(bus.out_valid), 32'd0);
    chk("ovf_empty_cnt", 32'(bus.fifo_count), 32'd0);

    // Reset clears sticky flags
    at(59);
    chk("rst2_ovf", 32'(bus.overflow), 32'd0);
    chk("rst2_sat", 32'(bus.saturated), 32'd0);
    chk("rst2_count", 32'(bus.fifo_count), 32'd0);

    // Full FIFO with a simultaneous pop and push
    at(67);
    chk("fp_count3", 32'(bus.fifo_count), 32'd3);
    at(68);
    chk("fp_count4", 32'(bus.fifo_count), 32'd4);
    chk("fp_head8", 32'(bus.out_idx), 32'd8);
    at(69);
    chk("fp_count_kept", 32'(bus.fifo_count), 32'd4);
    chk("fp_no_ovf", 32'(bus.overflow), 32'd0);
    chk("fp_head9", 32'(bus.out_idx), 32'd9);
    at(70);
    chk("fp_hold9", 32'(bus.out_idx), 32'd9);
    for (int k = 0; k < 4; k++) begin
      at(71 + k);
      chk("fp_drain_idx", 32'(bus.out_idx), 32'(9 + k));
      chk("fp_drain_d0", bus.out_data[0], 32'(2001 + k));
    end
    at(75);
    chk("fp_empty", 32'(bus.out_valid), 32'd0);

    // Reset two cycles after in_valid discards the vector and the one on the reset edge
    at(83);
    chk("mid_count", 32'(bus.fifo_count), 32'd0);
    chk("mid_ovf", 32'(bus.overflow), 32'd0);
    chk("mid_sat", 32'(bus.saturated), 32'd0);
    for (int n = 83; n <= 92; n++) begin
      at(n);
      chk("mid_no_valid", 32'(bus.out_valid), 32'd0);
    end

    // Normal operation resumes after reset
    at(99);
    chk("resume_early", 32'(bus.out_valid), 32'd0);
    at(100);
    chk("resume_valid", 32'(bus.out_valid), 32'd1);
    chk("resume_idx", 32'(bus.out_idx), 32'd4);
    chk("resume_d1", bus.out_data[1], 32'hFFFF_FFFF);
    chk("resume_d3", bus.out_data[3], 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
